// File: rtl/wb_pkg.sv
// Shared widths, state encoding and constants for the writeback stage.
package wb_pkg;

   localparam int unsigned DATA_W     = 16;
   localparam int unsigned REG_ADDR_W = 3;

   localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      WAIT_MEM = 2'd1,
      COMMIT   = 2'd2
   } wb_state_e;

endpackage

// File: rtl/wb_retire_ctr.sv
// 16-bit wrapping retired-instruction counter with async active-low clear.
module wb_retire_ctr (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        inc_i,
   output logic [15:0] count_o
);

   logic [15:0] count_q;
   logic [15:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc_i) count_d = count_q + 16'd1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) count_q <= '0;
      else         count_q <= count_d;
   end

   assign count_o = count_q;

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: selects ALU or load result and issues one registered write.
// Optional decode bypass port enabled by defining WB_FWD_EN.
module wb_stage
   import wb_pkg::*;
(
   input  logic                  CLK,
   input  logic                  RST_N,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic                  in_regWrite,
   input  logic [REG_ADDR_W-1:0] in_writeReg,
   input  logic                  in_isLoad,
   input  logic [DATA_W-1:0]     in_aluResult,
   input  logic [DATA_W-1:0]     mem_rdata,
   input  logic                  mem_rvalid,
   output logic                  RegWrite,
   output logic [REG_ADDR_W-1:0] writeReg,
   output logic [DATA_W-1:0]     writeValue,
   output logic                  busy,
   output logic [15:0]           retired,
   output logic                  fwd_valid,
   output logic [REG_ADDR_W-1:0] fwd_reg,
   output logic [DATA_W-1:0]     fwd_value
);

   wb_state_e             state_q, state_d;
   logic [REG_ADDR_W-1:0] wreg_q, wreg_d;
   logic [DATA_W-1:0]     wval_q, wval_d;
   logic                  wen_q, wen_d;
   logic                  accept;

   assign in_ready = (state_q != WAIT_MEM);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d = state_q;
      wreg_d  = wreg_q;
      wval_d  = wval_q;
      wen_d   = wen_q;
      case (state_q)
         WAIT_MEM: begin
            if (mem_rvalid) begin
               wval_d  = mem_rdata;
               state_d = COMMIT;
            end
         end
         COMMIT:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // accept overrides the COMMIT->IDLE default; r0 suppression decided at latch time
      if (accept) begin
         wreg_d = in_writeReg;
         wen_d  = in_regWrite && (in_writeReg != ZERO_REG);
         if (in_isLoad) begin
            state_d = WAIT_MEM;
         end else begin
            wval_d  = in_aluResult;
            state_d = COMMIT;
         end
      end
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q <= IDLE;
         wreg_q  <= '0;
         wval_q  <= '0;
         wen_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wreg_q  <= wreg_d;
         wval_q  <= wval_d;
         wen_q   <= wen_d;
      end
   end

   assign RegWrite   = (state_q == COMMIT) && wen_q;
   assign writeReg   = wreg_q;
   assign writeValue = wval_q;
   assign busy       = (state_q == WAIT_MEM);

   wb_retire_ctr u_retire_ctr (
      .clk_i   (CLK),
      .rst_ni  (RST_N),
      .inc_i   (state_q == COMMIT),
      .count_o (retired)
   );

`ifdef WB_FWD_EN
   assign fwd_valid = RegWrite;
   assign fwd_reg   = writeReg;
   assign fwd_value = writeValue;
`else
   assign fwd_valid = 1'b0;
   assign fwd_reg   = '0;
   assign fwd_value = '0;
`endif

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the 16-bit, 8-register datapath. It sits directly upstream of `reg_file` and is the only driver of `RegWrite`, `writeReg` and `writeValue`. It accepts one retiring instruction per handshake and selects either the ALU result or the data-memory load result. It stalls on loads until memory returns data, and presents a registered single-cycle write to the register file. It also keeps a retired-instruction count and, optionally, a forwarding port.

## Interface
- `DATA_W`, 16, datapath width.
- `REG_ADDR_W`, 3, register address width (8 registers, r0 hardwired zero).
- `CLK`  in  1  rising-edge clock, shared with `reg_file`.
- `RST_N`  in  1  asynchronous, active-low reset. One clock domain.
- `in_valid`  in  1  upstream has an instruction to retire.
- `in_ready`  out  1  stage can accept this cycle.
- `in_regWrite`  in  1  instruction writes a register.
- `in_writeReg`  in  REG_ADDR_W  destination register.
- `in_isLoad`  in  1  result comes from data memory.
- `in_aluResult`  in  DATA_W  ALU result.
- `mem_rdata`  in  DATA_W  load data.
- `mem_rvalid`  in  1  `mem_rdata` is valid this cycle.
- `RegWrite`  out  1  register-file write enable.
- `writeReg`  out  REG_ADDR_W  register-file write address.
- `writeValue`  out  DATA_W  register-file write data.
- `busy`  out  1  a load is pending.
- `retired`  out  16  count of retired instructions; wraps.
- `fwd_valid`  out  1  forwarding value valid (only with `WB_FWD_EN`).
- `fwd_reg`  out  REG_ADDR_W  forwarding destination.
- `fwd_value`  out  DATA_W  forwarding data.

## Operation
- **FSM states:** IDLE, WAIT_MEM, COMMIT.
- **Accept:** `in_ready` = 1 in IDLE and COMMIT, 0 in WAIT_MEM. An instruction is accepted on `in_valid && in_ready`.
- **Accepted non-load:** latch `in_aluResult` and `in_writeReg`; next state COMMIT.
- **Accepted load:** latch `in_writeReg`; next state WAIT_MEM; `busy` = 1.
- **WAIT_MEM:**
  - On `mem_rvalid`: latch `mem_rdata`; next state COMMIT.
  - Otherwise stay in WAIT_MEM indefinitely.
- **COMMIT:** outputs drive the latched write for exactly one cycle.
  - If a new accept occurs in the same cycle, go to COMMIT (non-load) or WAIT_MEM (load).
  - Otherwise go to IDLE.
- **RegWrite:** = 1 only in COMMIT, with `in_regWrite` latched 1 and `writeReg` ≠ 0. Writes to r0 are suppressed here, not left to `reg_file`.
- **retired:** increments by 1 on every COMMIT cycle, including suppressed and no-write instructions. 0xFFFF wraps to 0x0000.
- **Ignored mem_rvalid:** ignored in IDLE and COMMIT, and ignored in the cycle a load is accepted. Load data must arrive at least one cycle after acceptance.
- **Reset:**
  - State IDLE; `RegWrite`, `writeReg`, `writeValue`, `busy`, `retired` and all `fwd_*` = 0; `in_ready` = 1.
  - Reset during WAIT_MEM discards the pending load without any write.

## Timing
- **ALU op:** accepted at edge N; `RegWrite`/`writeValue` valid in cycle N→N+1; `reg_file` captures at edge N+1. Latency 1, throughput 1 per cycle.
- **Load:** `mem_rvalid` sampled at edge M; write visible in cycle M→M+1.
- **Registered outputs:** `RegWrite`, `writeReg`, `writeValue` are registered (no combinational path from inputs). `in_ready` is decoded from state only.
- **Consumer contract:** `reg_file` writes on the rising edge, so a value written in COMMIT is readable by `reg_file` reads from the following cycle.

## Configuration
- **With `WB_FWD_EN` defined:** `fwd_valid`, `fwd_reg` and `fwd_value` mirror `RegWrite`, `writeReg` and `writeValue` in the same cycle, for a decode-stage bypass.
- **Without it:** the ports exist but are tied to 0. No forwarding logic is synthesised.

## Structure
- **`wb_pkg`:** holds `DATA_W`, `REG_ADDR_W`, the state typedef (IDLE=2'd0, WAIT_MEM=2'd1, COMMIT=2'd2) and the `ZERO_REG` constant.
- **Sub-module `wb_retire_ctr`:** 16-bit wrapping counter with async active-low clear and an increment input, instantiated once.

## Test plan
- **Reset:** assert `RST_N`=0 mid-stream → all outputs 0, `in_ready`=1, `retired`=0.
- **ALU op:** r2 ← 0x00A7 → `RegWrite`=1, `writeReg`=2, `writeValue`=0x00A7 for one cycle after accept; `retired`=1.
- **Write to r0:** r0 ← 0x2030 → `RegWrite`=0, `retired` increments.
- **Load:** to r6, with `mem_rvalid` 3 cycles later carrying 0x0013 → `in_ready`=0 and `busy`=1 for 3 cycles, then r6 written 0x0013. A back-to-back ALU op r3 ← 0xABCD follows with no bubble.
- **Reset in WAIT_MEM:** pulse reset while a load is pending → no write ever issues; a later `mem_rvalid` is ignored.
- **Wrap and forwarding:** preload `retired` at 0xFFFF, retire one instruction → 0x0000. With `WB_FWD_EN`, check `fwd_value`=`writeValue`; without it, check `fwd_*`=0.
